// File: rtl/pattern_loader_pkg.sv
// pattern_loader_pkg
//   Shared constants and types for the pattern loader slice.
//   - State codes for the frame parser (legacy-style localparam constants).
//   - ACK/NAK response bytes used when PATTERN_LOADER_ACK_EN is defined.
//   - Default frame sync marker and pattern RAM depth.
package pattern_loader_pkg;

  localparam int         PATTERN_DEPTH     = 256;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t ADDR    = 3'd1;
  localparam state_t COUNT   = 3'd2;
  localparam state_t DATA_HI = 3'd3;
  localparam state_t DATA_LO = 3'd4;
  localparam state_t CSUM    = 3'd5;

endpackage

// File: rtl/pattern_loader_if.sv
// pattern_loader_if
//   Byte link in, RAM write port out, plus loader status.
//   Signals:
//     rx_data[7:0], rx_valid  : received byte and its one-cycle strobe
//     wr_en, wr_addr[7:0],
//     wr_data[15:0]           : pattern RAM write port
//     hold                    : frame in progress, playback must not start a note
//     done, error             : one-cycle frame result pulses
//     tx_data[7:0], tx_valid  : ACK/NAK response (only with PATTERN_LOADER_ACK_EN)
//   Modports: master = byte source / status consumer, slave = the loader.
interface pattern_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        hold;
  logic        done;
  logic        error;
`ifdef PATTERN_LOADER_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;

  modport master (output rx_data, rx_valid,
                  input  wr_en, wr_addr, wr_data, hold, done, error, tx_data, tx_valid);
  modport slave  (input  rx_data, rx_valid,
                  output wr_en, wr_addr, wr_data, hold, done, error, tx_data, tx_valid);
`else
  modport master (output rx_data, rx_valid,
                  input  wr_en, wr_addr, wr_data, hold, done, error);
  modport slave  (input  rx_data, rx_valid,
                  output wr_en, wr_addr, wr_data, hold, done, error);
`endif

endinterface

// File: rtl/pattern_loader_frame_timeout.sv
// frame_timeout
//   Inter-byte watchdog for the pattern loader.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     i_clear      : an accepted byte, restarts the count
//     i_run        : a frame is in progress
//     o_expired    : high in the cycle whose edge completes TIMEOUT_CYCLES idle cycles
//   TIMEOUT_CYCLES must be >= 2.
module frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count holds the number of idle edges since the last byte; the edge on
  // which count already equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th one.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || !i_run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // A byte arriving in the expiry cycle wins, so clear masks the pulse.
  assign o_expired = i_run && !i_clear && (count == LAST);

endmodule

// File: rtl/pattern_loader.sv
// pattern_loader
//   Parses SYNC, ADDR, COUNT, COUNT x (HI, LO), CSUM frames from a byte link
//   and writes 16-bit words into the 256x16 pattern RAM, holding playback off
//   while a frame is in progress.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     bus          : pattern_loader_if.slave (byte in, RAM write, hold/done/error,
//                    and tx_data/tx_valid when PATTERN_LOADER_ACK_EN is defined)
//   Optional feature macro: PATTERN_LOADER_ACK_EN (ACK/NAK byte on frame end).
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pattern_loader_if.slave  bus
);

  state_t     state;
  logic [7:0] ptr;
  logic [7:0] sum;
  logic [7:0] hi;
  logic [8:0] remaining;
  logic [7:0] final_sum;
  logic       expired;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (bus.rx_valid),
    .i_run     (state != IDLE),
    .o_expired (expired)
  );

  assign final_sum = sum + bus.rx_data;

  // Frame parser; every output is registered, so each effect shows up the
  // cycle after the byte that caused it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      ptr          <= '0;
      sum          <= '0;
      hi           <= '0;
      remaining    <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.hold     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
`ifdef PATTERN_LOADER_ACK_EN
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
`ifdef PATTERN_LOADER_ACK_EN
      bus.tx_valid <= 1'b0;
`endif
      if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state    <= ADDR;
              bus.hold <= 1'b1;
            end
          end
          ADDR: begin
            ptr   <= bus.rx_data;
            sum   <= bus.rx_data;
            state <= COUNT;
          end
          COUNT: begin
            // A zero count byte encodes a full 256-word image.
            remaining <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
            sum       <= final_sum;
            state     <= DATA_HI;
          end
          DATA_HI: begin
            hi    <= bus.rx_data;
            sum   <= final_sum;
            state <= DATA_LO;
          end
          DATA_LO: begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= {hi, bus.rx_data};
            ptr         <= ptr + 8'd1;
            remaining   <= remaining - 9'd1;
            sum         <= final_sum;
            state       <= (remaining == 9'd1) ? CSUM : DATA_HI;
          end
          CSUM: begin
            state    <= IDLE;
            bus.hold <= 1'b0;
            if (final_sum == 8'h00) begin
              bus.done <= 1'b1;
            end else begin
              bus.error <= 1'b1;
            end
`ifdef PATTERN_LOADER_ACK_EN
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= (final_sum == 8'h00) ? ACK_BYTE : NAK_BYTE;
`endif
          end
          default: begin
            state    <= IDLE;
            bus.hold <= 1'b0;
          end
        endcase
      end else if (expired) begin
        // Abandon the frame; any half-received word is simply dropped.
        state     <= IDLE;
        bus.hold  <= 1'b0;
        bus.error <= 1'b1;
`ifdef PATTERN_LOADER_ACK_EN
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= NAK_BYTE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// tb_pattern_loader
//   Scoreboard bench for pattern_loader: stimulus tasks push the expected
//   RAM writes and frame results, a monitor pops and compares them as the
//   DUT presents them. Build with PATTERN_LOADER_ACK_EN to also check ACK/NAK.
module tb_pattern_loader;
  import pattern_loader_pkg::*;

  localparam int TO = 50;

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 error
    logic [7:0]  addr;
    logic [15:0] data;
    longint      when;
  } ev_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  ev_t    exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_loader_if bus ();

  pattern_loader #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] addr, input logic [15:0] data,
                         input longint when);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.when = when;
    exp_q.push_back(e);
  endtask

  // Caller is at a negedge; the byte is sampled on the next posedge and this
  // returns at the following negedge, where registered outputs are visible.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: the checksum byte is whatever makes ADDR+COUNT+data+CSUM
  // vanish mod 256; a bad frame perturbs it by a non-zero amount.
  task automatic sendFrame(input logic [7:0] addr, input int n, input logic [15:0] words[$],
                           input int bad_off, input int max_gap);
    logic [7:0] cnt_byte;
    logic [7:0] total;
    logic [7:0] csum;
    int         k;
    cnt_byte = (n == 256) ? 8'h00 : n[7:0];
    total    = addr + cnt_byte;
    for (int i = 0; i < n; i++) total = total + words[i][15:8] + words[i][7:0];
    csum = 8'(0 - int'(total) + bad_off);
    applyStimulus(8'hA5);
    checkOutput("hold_after_sync", {31'd0, bus.hold}, 32'd1);
    idle($urandom_range(max_gap, 0));
    applyStimulus(addr);
    idle($urandom_range(max_gap, 0));
    applyStimulus(cnt_byte);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(max_gap, 0));
      applyStimulus(words[i][15:8]);
      idle($urandom_range(max_gap, 0));
      push_ev(0, 8'(int'(addr) + i), words[i], cyc + 1);
      applyStimulus(words[i][7:0]);
    end
    idle($urandom_range(max_gap, 0));
    k = (bad_off % 256 == 0) ? 1 : 2;
    push_ev(k, 8'h00, 16'h0000, cyc + 1);
    applyStimulus(csum);
    checkOutput("hold_after_csum", {31'd0, bus.hold}, 32'd0);
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    int  k;
    bit  ok;
    ev_t e;
    if (!rst && (bus.wr_en || bus.done || bus.error)) begin
      k = 9;
      if (bus.wr_en && !bus.done && !bus.error) k = 0;
      else if (!bus.wr_en && bus.done && !bus.error) k = 1;
      else if (!bus.wr_en && !bus.done && bus.error) k = 2;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_event kind=%0d addr=%0h data=%0h cyc=%0d required=none",
                 k, bus.wr_addr, bus.wr_data, cyc);
      end else begin
        e  = exp_q.pop_front();
        ok = (k == e.kind) && (cyc == e.when);
        if (k == 0) ok = ok && (bus.wr_addr == e.addr) && (bus.wr_data == e.data);
`ifdef PATTERN_LOADER_ACK_EN
        if (k != 0) ok = ok && bus.tx_valid && (bus.tx_data == ((k == 1) ? ACK_BYTE : NAK_BYTE));
`endif
        if (!ok) begin
          fails++;
          $display("[TB] FAIL event actual kind=%0d addr=%0h data=%0h cyc=%0d required kind=%0d addr=%0h data=%0h cyc=%0d",
                   k, bus.wr_addr, bus.wr_data, cyc, e.kind, e.addr, e.data, e.when);
        end
      end
    end
`ifdef PATTERN_LOADER_ACK_EN
    if (!rst && bus.tx_valid && !(bus.done || bus.error)) begin
      tests++;
      fails++;
      $display("[TB] FAIL stray_tx actual tx_data=%0h required no tx_valid", bus.tx_data);
    end
`endif
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w[$];
    int          n;
    int          noise;
    logic [7:0]  nb;
    logic [31:0] tmp;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    idle(3);
    checkOutput("reset_outputs",
                {4'd0, bus.wr_en, bus.hold, bus.done, bus.error, bus.wr_addr, bus.wr_data}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single word, good and bad checksum.
    w = '{16'h1234};
    sendFrame(8'h10, 1, w, 0, 0);
    idle(3);
    sendFrame(8'h10, 1, w, 1, 0);
    idle(3);

    // Pointer wraps FE, FF, 00.
    w = '{16'h0001, 16'h0002, 16'h0003};
    sendFrame(8'hFE, 3, w, 0, 1);
    idle(3);

    // Timeout after a lone HI byte: error exactly TO cycles after it.
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h01);
    push_ev(2, 8'h00, 16'h0000, cyc + 1 + TO);
    applyStimulus(8'h12);
    idle(TO + 5);
    checkOutput("hold_after_timeout", {31'd0, bus.hold}, 32'd0);
    w = '{16'hBEEF};
    sendFrame(8'h40, 1, w, 0, 0);
    idle(3);

    // Noise, a sync, SYNC-valued ADDR, then reset mid-frame.
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("hold_after_reset", {31'd0, bus.hold}, 32'd0);
    idle(2);
    w = '{16'hA5A5, 16'h5A5A};
    sendFrame(8'h20, 2, w, 0, 0);
    idle(3);

    // Full 256-word image.
    w = {};
    for (int i = 0; i < 256; i++) begin
      tmp = $urandom;
      w.push_back(tmp[15:0]);
    end
    sendFrame(8'h00, 256, w, 0, 0);
    idle(3);

    // Randomized frames with inter-frame noise and inter-byte gaps.
    for (int f = 0; f < 30; f++) begin
      noise = $urandom_range(2, 0);
      for (int j = 0; j < noise; j++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        applyStimulus(nb);
        idle($urandom_range(2, 0));
      end
      n = $urandom_range(6, 1);
      w = {};
      for (int i = 0; i < n; i++) begin
        tmp = $urandom;
        w.push_back(tmp[15:0]);
      end
      tmp = $urandom;
      sendFrame(tmp[7:0], n, w, ($urandom_range(3, 0) == 0) ? $urandom_range(255, 1) : 0, 3);
      idle($urandom_range(3, 1));
    end

    idle(10);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
